// File: rtl/conv2d_pool_stream.sv
// conv2d_pool_stream: 2x2/stride-2 max pooling, ReLU, shift requantisation and
// saturation over one latched conv result frame; pooled pixels leave serially
// on a valid/ready stream, map-major then row-major.
module conv2d_pool_stream #(
    parameter int unsigned BITWIDTH                 = 8,
    parameter int unsigned IS_BITWIDTH_DOUBLE_SCALE = 1,
    parameter int unsigned OUT_WIDTH                = 26,
    parameter int unsigned OUT_HEIGHT               = 26,
    parameter int unsigned KERNEL_NUM               = 1,
    parameter int unsigned SHIFT                    = 4,
    localparam int unsigned AW  = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1),
    localparam int unsigned FMN = OUT_WIDTH * OUT_HEIGHT,
    localparam int unsigned KW  = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KERNEL_NUM*FMN*AW-1:0] channel_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH-1:0]          out_data,
    output logic [KW-1:0]                out_kernel,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned TOT  = KERNEL_NUM * FMN * AW;
    localparam int unsigned PW   = OUT_WIDTH / 2;
    localparam int unsigned PH   = OUT_HEIGHT / 2;
    localparam int unsigned PRW  = (PH > 1) ? $clog2(PH) : 1;
    localparam int unsigned PCW  = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned MAXV = (2 ** (BITWIDTH - 1)) - 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWin  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [TOT-1:0]       frame_q;
    logic [KW-1:0]        k_q, k_d;
    logic [PRW-1:0]       pr_q, pr_d;
    logic [PCW-1:0]       pc_q, pc_d;
    logic [1:0]           win_q, win_d;
    logic signed [AW-1:0] max_q, max_d;
    logic                 out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0]  out_data_q, out_data_d;
    logic [KW-1:0]        out_kernel_q, out_kernel_d;
    logic                 out_last_q, out_last_d;

    logic                 frame_load;
    logic [31:0]          row, col, elem_idx;
    logic signed [AW-1:0] elem, win_max;
    logic [AW-1:0]        shifted;
    logic [BITWIDTH-1:0]  quant;
    logic                 is_last;

    assign frame_load = (state_q == StIdle) && in_valid && !rst;
    assign in_ready   = (state_q == StIdle) && !rst;
    assign busy       = (state_q != StIdle);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_kernel = out_kernel_q;
    assign out_last   = out_last_q;

    // Fetch the current window element and fold it into the running max, then requantise
    always_comb begin
        row      = 32'(pr_q) * 2 + {31'd0, win_q[1]};
        col      = 32'(pc_q) * 2 + {31'd0, win_q[0]};
        elem_idx = 32'(k_q) * FMN + row * OUT_WIDTH + col;
        elem     = frame_q[TOT - 1 - elem_idx * AW -: AW];
        if (win_q == 2'd0 || elem > max_q) begin
            win_max = elem;
        end else begin
            win_max = max_q;
        end
        shifted = $unsigned(win_max) >> SHIFT;
        if (win_max[AW-1]) begin
            quant = '0;
        end else if (shifted > AW'(MAXV)) begin
            quant = BITWIDTH'(MAXV);
        end else begin
            quant = shifted[BITWIDTH-1:0];
        end
        is_last = (32'(k_q) == KERNEL_NUM - 1) && (32'(pr_q) == PH - 1) &&
                  (32'(pc_q) == PW - 1);
    end

    // Next-state logic: frame accept, 4-cycle window scan, output handshake and index advance
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pr_d         = pr_q;
        pc_d         = pc_q;
        win_d        = win_q;
        max_d        = max_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_kernel_d = out_kernel_q;
        out_last_d   = out_last_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StWin;
                    k_d     = '0;
                    pr_d    = '0;
                    pc_d    = '0;
                    win_d   = '0;
                end
            end
            StWin: begin
                max_d = win_max;
                win_d = win_q + 2'd1;
                if (win_q == 2'd3) begin
                    state_d      = StOut;
                    out_valid_d  = 1'b1;
                    out_data_d   = quant;
                    out_kernel_d = k_q;
                    out_last_d   = is_last;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWin;
                        win_d   = '0;
                        if (32'(pc_q) == PW - 1) begin
                            pc_d = '0;
                            if (32'(pr_q) == PH - 1) begin
                                pr_d = '0;
                                k_d  = k_q + KW'(1);
                            end else begin
                                pr_d = pr_q + PRW'(1);
                            end
                        end else begin
                            pc_d = pc_q + PCW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            pr_q         <= '0;
            pc_q         <= '0;
            win_q        <= '0;
            max_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_kernel_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pr_q         <= pr_d;
            pc_q         <= pc_d;
            win_q        <= win_d;
            max_q        <= max_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_kernel_q <= out_kernel_d;
            out_last_q   <= out_last_d;
        end
    end

    // Private copy of the frame so the upstream buffer is free once accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (frame_load) begin
            frame_q <= channel_in;
        end
    end

endmodule

// File: doc/conv2d_pool_stream.md
Name: conv2d_pool_stream

Overview:
- Downstream stage of the per-channel conv2d block.
- Accepts one complete flattened conv result vector: KERNEL_NUM maps of OUT_HEIGHT x OUT_WIDTH double-width signed sums.
- Applies 2x2/stride-2 max pooling, ReLU, arithmetic right-shift requantisation and saturation to BITWIDTH.
- Emits pooled pixels serially on a valid/ready stream toward the next layer's buffer.

Parameters:
- BITWIDTH, 8, output pixel width.
- IS_BITWIDTH_DOUBLE_SCALE, 1, input element width AW = BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1).
- OUT_WIDTH, 26, conv output map width.
- OUT_HEIGHT, 26, conv output map height.
- KERNEL_NUM, 1, number of maps in the input vector.
- SHIFT, 4, requant right-shift amount, 0..AW-1.
- Derived: FMN = OUT_WIDTH*OUT_HEIGHT; PW = OUT_WIDTH/2; PH = OUT_HEIGHT/2 (floor division).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  channel_in holds a complete frame.
- in_ready  out  1  block can accept a frame.
- channel_in  in  KERNEL_NUM*FMN*AW  signed conv results. Element (k,p), p = r*OUT_WIDTH + c, is at [KERNEL_NUM*FMN*AW-1 - (k*FMN+p)*AW -: AW].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  BITWIDTH  signed pooled pixel, range 0..2^(BITWIDTH-1)-1.
- out_kernel  out  max(1,clog2(KERNEL_NUM))  map index of out_data.
- out_last  out  1  final pixel of the frame.
- busy  out  1  frame in progress.

Behaviour:
- Single clock domain; all state changes on posedge clk. rst is synchronous and active-high.
- Reset state:
  - out_valid=0, out_data=0, out_kernel=0, out_last=0, busy=0.
  - Internal frame register and counters cleared; FSM goes to IDLE.
  - in_ready=0 during any cycle rst is high.
  - Reset mid-frame aborts the frame; no further outputs for it.
- FSM states: IDLE, WIN, OUT.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&in_ready, latch channel_in into an internal register, clear indices (k=0, pr=0, pc=0, win=0) and go to WIN.
  - channel_in may change after acceptance.
- WIN (exactly 4 cycles, win=0..3):
  - Visits window elements (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1) in that order.
  - win=0 loads the running max; win=1..3 keep the signed max.
  - After win=3, go to OUT.
- OUT:
  - out_valid=1.
  - out_data = sat(relu(max) >>> SHIFT). relu maps negative values to 0; sat clamps to 2^(BITWIDTH-1)-1.
  - out_kernel=k; out_last=1 iff k=KERNEL_NUM-1, pr=PH-1, pc=PW-1.
  - out_data, out_kernel and out_last hold stable while out_valid&!out_ready.
  - On out_valid&out_ready, out_valid drops next cycle:
    - if last pixel, go to IDLE;
    - else advance pc, then pr, then k (map-major, row-major) and go to WIN.
- Latency:
  - Frame accepted in cycle T gives the first out_valid in cycle T+5.
  - With out_ready held high, one output every 5 cycles.
  - in_ready returns to 1 the cycle after the last handshake.
- Odd OUT_WIDTH/OUT_HEIGHT: last column/row never read.
- in_valid while busy is ignored; no back-to-back overlap.
- busy=1 in WIN and OUT.
- out_data is derived only from the latched copy of the frame.

Test Plan (unless stated: BITWIDTH=8, AW=16, OUT_WIDTH=4, OUT_HEIGHT=4, KERNEL_NUM=2, SHIFT=2, out_ready=1):
1. Basic pixel and latency: k0 window(0,0) = 5, 9, -3, 20; frame accepted at T -> out_valid at T+5, out_data=5, out_kernel=0, out_last=0.
2. ReLU: window of all negatives (-1, -100, -32768, -7) -> out_data=0.
3. Saturation: window max 1000 -> 1000>>2 = 250 -> out_data=127; window max 511 -> out_data=127; max 508 -> 127; max 500 -> 125.
4. Backpressure and ordering: hold out_ready=0 for 3 cycles during the first OUT -> out_data/out_kernel stable, no index advance. Full frame yields 8 outputs, 4 per kernel, in order (k,pr,pc) = (0,0,0), (0,0,1), (0,1,0), (0,1,1), (1,...). out_last=1 only on the 8th with out_kernel=1; in_ready=1 the next cycle.
5. Odd dimensions: OUT_WIDTH=5, OUT_HEIGHT=5, KERNEL_NUM=1; plant 30000 in column 4 and row 4 -> 4 outputs, none equal 127 from those cells; out_last on the 4th.
6. Reset and busy guard:
   - in_valid pulsed with a new frame while busy -> ignored; outputs match the first frame.
   - rst asserted after the 2nd output -> next cycle out_valid=0, busy=0, in_ready=1 after rst deasserts.
   - New frame then restarts from (0,0,0).
